mac_job_scheduler: RTL and testbench

Round-robin job scheduler that shares one pipelined MAC datapath among `NUM_REQ` requesters. Each requester submits a dot-product job of `len` operand pairs. The scheduler then:
- grants the MAC to one requester,
- clears the accumulator,
- streams that requester's operands into the MAC,
- flushes the MAC pipeline,
- returns the final accumulator value tagged with the requester id.

It sits between the requesting engines and the MAC unit and is the only driver of the MAC's `valid`/`clear`/operand inputs.

---
 rtl/mac_job_scheduler.sv | 115 +++++++++++
 tb/tb_mac_job_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: round-robin arbiter that runs one requester's dot-product job at a time on a shared MAC.
module mac_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RESULT_LAT = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            op_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]            op_ready,
  output logic                          mac_valid,
  output logic                          mac_clear,
  output logic [DATA_WIDTH-1:0]         mac_multiplier,
  output logic [DATA_WIDTH-1:0]         mac_multiplicand,
  input  logic [ACC_WIDTH-1:0]          mac_result,
  output logic                          done_valid,
  output logic [IW-1:0]                 done_id,
  output logic [ACC_WIDTH-1:0]          done_result,
  input  logic                          done_ready,
  output logic                          busy
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_WAIT, S_DONE} state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_ptr, r_gnt, r_done_id, w_gnt, w_idx;
  logic                  w_found, w_beat, w_last, w_wait_end;
  logic [LEN_WIDTH-1:0]  r_len, r_beat_cnt, w_cnt_nx;
  logic [7:0]            r_wait;
  logic                  r_mac_valid, r_mac_clear;
  logic [DATA_WIDTH-1:0] r_mac_a, r_mac_b;
  logic [ACC_WIDTH-1:0]  r_done_result;

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_cnt_nx   = r_beat_cnt + LEN_WIDTH'(1);
  assign w_beat     = (r_state == S_STREAM) && op_valid[r_gnt];
  assign w_last     = w_beat && (w_cnt_nx == r_len);
  assign w_wait_end = (r_state == S_WAIT) && (r_wait == 8'(RESULT_LAT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_CLEAR;
      S_CLEAR:  w_next = (r_len == '0) ? S_FLUSH : S_STREAM;
      S_STREAM: if (w_last) w_next = S_FLUSH;
      S_FLUSH:  w_next = S_WAIT;
      S_WAIT:   if (w_wait_end) w_next = S_DONE;
      S_DONE:   if (done_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_len         <= '0;
      r_beat_cnt    <= '0;
      r_wait        <= '0;
      r_mac_valid   <= 1'b0;
      r_mac_clear   <= 1'b0;
      r_mac_a       <= '0;
      r_mac_b       <= '0;
      r_done_id     <= '0;
      r_done_result <= '0;
    end else begin
      r_state     <= w_next;
      r_mac_valid <= (r_state == S_CLEAR) || (r_state == S_FLUSH) || w_beat;
      r_mac_clear <= r_state == S_CLEAR;
      r_mac_a     <= w_beat ? op_a[r_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
      r_mac_b     <= w_beat ? op_b[r_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
      r_beat_cnt  <= (r_state == S_CLEAR) ? '0 : w_beat ? w_cnt_nx : r_beat_cnt;
      r_wait      <= (r_state == S_WAIT) ? r_wait + 8'd1 : 8'd0;
      if (r_state == S_IDLE && w_found) begin
        r_gnt <= w_gnt;
        r_len <= req_len[w_gnt*LEN_WIDTH +: LEN_WIDTH];
        r_ptr <= (w_gnt == IW'(NUM_REQ - 1)) ? '0 : w_gnt + IW'(1);
      end
      if (w_wait_end) begin
        r_done_result <= mac_result;
        r_done_id     <= r_gnt;
      end
    end
  end

  assign req_ready        = (r_state == S_IDLE && w_found && !reset) ? NUM_REQ'(1) << w_gnt : '0;
  assign op_ready         = (r_state == S_STREAM) ? NUM_REQ'(1) << r_gnt : '0;
  assign busy             = r_state != S_IDLE;
  assign done_valid       = r_state == S_DONE;
  assign done_id          = r_done_id;
  assign done_result      = r_done_result;
  assign mac_valid        = r_mac_valid;
  assign mac_clear        = r_mac_clear;
  assign mac_multiplier   = r_mac_a;
  assign mac_multiplicand = r_mac_b;
endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb_mac_job_scheduler: directed checks of mac_job_scheduler against an ideal two-stage MAC.
module tb_mac_job_scheduler;
  localparam int N = 4, DW = 16, AW = 32, LW = 8, IW = 2;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]    req_valid, req_ready, op_valid, op_ready;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] op_a, op_b;
  logic            mac_valid, mac_clear, done_valid, done_ready, busy;
  logic [DW-1:0]   mac_multiplier, mac_multiplicand;
  logic [AW-1:0]   mac_result, done_result;
  logic [IW-1:0]   done_id;

  mac_job_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_multiplier(mac_multiplier),
    .mac_multiplicand(mac_multiplicand), .mac_result(mac_result), .done_valid(done_valid),
    .done_id(done_id), .done_result(done_result), .done_ready(done_ready), .busy(busy)
  );

  // ideal MAC: product stage then accumulator; it is never reset, so only mac_clear can zero it
  logic signed [AW-1:0] m_acc = '0, m_p = '0;
  logic m_pv = 1'b0, m_pc = 1'b0;
  always @(posedge clk) begin
    m_pv <= mac_valid;
    m_pc <= mac_clear;
    if (mac_valid) begin
      if (mac_clear) m_p <= '0;
      else m_p <= $signed(mac_multiplier) * $signed(mac_multiplicand);
    end
    if (m_pv) begin
      if (m_pc) m_acc <= '0;
      else m_acc <= m_acc + m_p;
    end
  end
  assign mac_result = m_acc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] da[N][8], db[N][8];
  int idx[N];
  bit phase[N];
  logic stall = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!busy) begin
        idx[i] = 0;
        phase[i] = 1'b1;
      end
      op_valid[i] = stall ? phase[i] : 1'b1;
      op_a[i*DW +: DW] = da[i][idx[i]];
      op_b[i*DW +: DW] = db[i][idx[i]];
      if (op_ready[i]) begin
        if (op_valid[i]) idx[i] = (idx[i] + 1) & 7;
        phase[i] = ~phase[i];
      end
    end
  end

  int g_n = 0, d_n = 0, mv_cnt = 0, mc_cnt = 0, viol = 0, hs_cyc = 0, owner = 0;
  int g_id[32], g_cyc[32], d_id[32], d_cyc[32];
  logic [AW-1:0] d_res[32];
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    #1;
    if ($countones(req_ready) > 1 || (|req_ready && busy)) viol++;
    for (int i = 0; i < N; i++)
      if (req_ready[i] && g_n < 32) begin
        g_id[g_n] = i;
        g_cyc[g_n] = cyc;
        g_n++;
        owner = i;
      end
    if (|op_ready && op_ready != (N'(1) << owner)) viol++;
    if (mac_valid) mv_cnt++;
    if (mac_clear) mc_cnt++;
    if (done_valid && !prev_done && d_n < 32) begin
      d_id[d_n] = int'(done_id);
      d_res[d_n] = done_result;
      d_cyc[d_n] = cyc;
      d_n++;
    end
    if (done_valid && done_ready) hs_cyc = cyc;
    prev_done = done_valid;
  end

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic wait_grant(input int n0);
    int t = 0;
    while (g_n <= n0 && t < 200) begin @(negedge clk); t++; end
    chk("grant_timeout", 64'(g_n > n0), 1);
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (d_n <= n0 && t < 300) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(d_n > n0), 1);
  endtask

  int g0, d0, mv0, mc0;
  initial begin
    req_valid = '0;
    req_len = '0;
    done_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, mac_valid, mac_clear, done_valid, req_ready, op_ready, done_id}, 0);
    chk("rst_data", {mac_multiplier, mac_multiplicand, done_result}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ctl", {busy, mac_valid, mac_clear, done_valid, req_ready, op_ready}, 0);

    // round-robin: everyone requests, len=1, a=i+1, b=3
    for (int i = 0; i < N; i++) begin
      da[i][0] = DW'(i + 1);
      db[i][0] = 16'sd3;
      req_len[i*LW +: LW] = 8'd1;
    end
    g0 = g_n; d0 = d_n;
    req_valid = 4'hF;
    wait_grant(g0 + 4);
    req_valid = '0;
    wait_done(d0 + 4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_id%0d", k), g_id[g0+k], k % 4);
      chk($sformatf("rr_res%0d", k), d_res[d0+k], 3 * (k % 4 + 1));
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_gap%0d", k), g_cyc[g0+k+1] - g_cyc[g0+k], 8);

    // zero length on requester 2
    req_len[2*LW +: LW] = 8'd0;
    g0 = g_n; d0 = d_n; mv0 = mv_cnt; mc0 = mc_cnt;
    req_valid = 4'b0100;
    wait_grant(g0);
    req_valid = '0;
    wait_done(d0);
    chk("z_id", d_id[d0], 2);
    chk("z_res", d_res[d0], 0);
    chk("z_lat", d_cyc[d0] - g_cyc[g0], 6);
    chk("z_mv", mv_cnt - mv0, 2);
    chk("z_mc", mc_cnt - mc0, 1);

    // single job on requester 1: 2*3 + 4*5 + (-1)*7 = 19
    da[1][0] = 16'sd2; db[1][0] = 16'sd3;
    da[1][1] = 16'sd4; db[1][1] = 16'sd5;
    da[1][2] = -16'sd1; db[1][2] = 16'sd7;
    req_len[1*LW +: LW] = 8'd3;
    g0 = g_n; d0 = d_n; mv0 = mv_cnt; mc0 = mc_cnt;
    req_valid = 4'b0010;
    wait_grant(g0);
    req_valid = '0;
    wait_done(d0);
    chk("s_id", d_id[d0], 1);
    chk("s_res", d_res[d0], 19);
    chk("s_lat", d_cyc[d0] - g_cyc[g0], 9);
    chk("s_mv", mv_cnt - mv0, 5);
    chk("s_mc", mc_cnt - mc0, 1);

    // stalls on requester 3: 1*2 + 3*4 + 5*6 + 7*8 = 100, three dropouts
    for (int k = 0; k < 4; k++) begin
      da[3][k] = DW'(2 * k + 1);
      db[3][k] = DW'(2 * k + 2);
    end
    req_len[3*LW +: LW] = 8'd4;
    stall = 1'b1;
    g0 = g_n; d0 = d_n; mv0 = mv_cnt;
    req_valid = 4'b1000;
    wait_grant(g0);
    req_valid = '0;
    wait_done(d0);
    stall = 1'b0;
    chk("st_res", d_res[d0], 100);
    chk("st_lat", d_cyc[d0] - g_cyc[g0], 13);
    chk("st_mv", mv_cnt - mv0, 6);

    // back-pressure on requester 0: 10*10 + (-3)*4 = 88, requester 1 waits
    da[0][0] = 16'sd10; db[0][0] = 16'sd10;
    da[0][1] = -16'sd3; db[0][1] = 16'sd4;
    req_len[0*LW +: LW] = 8'd2;
    da[1][0] = 16'sd5; db[1][0] = 16'sd5;
    req_len[1*LW +: LW] = 8'd1;
    done_ready = 1'b0;
    g0 = g_n; d0 = d_n;
    req_valid = 4'b0001;
    wait_grant(g0);
    req_valid = 4'b0010;
    wait_done(d0);
    chk("bp_lat", d_cyc[d0] - g_cyc[g0], 8);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {done_valid, done_id, done_result}, {1'b1, 2'd0, 32'd88});
    end
    chk("bp_nogrant", g_n - g0, 1);
    done_ready = 1'b1;
    wait_grant(g0 + 1);
    req_valid = '0;
    chk("bp_next_id", g_id[g0+1], 1);
    chk("bp_next_cyc", g_cyc[g0+1] - hs_cyc, 1);
    wait_done(d0 + 1);
    chk("bp_next_res", d_res[d0+1], 25);

    // reset mid-stream on requester 2 after two of five beats
    for (int k = 0; k < 5; k++) begin
      da[2][k] = DW'(k + 1);
      db[2][k] = DW'(k + 1);
    end
    req_len[2*LW +: LW] = 8'd5;
    g0 = g_n; d0 = d_n;
    req_valid = 4'b0100;
    wait_grant(g0);
    req_valid = '0;
    while (cyc < g_cyc[g0] + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_ctl", {busy, mac_valid, mac_clear, done_valid, req_ready, op_ready}, 0);
    chk("mr_data", {mac_multiplier, mac_multiplicand}, 0);
    // fresh job: 6*7 + (-2)*3 = 36
    da[2][0] = 16'sd6; db[2][0] = 16'sd7;
    da[2][1] = -16'sd2; db[2][1] = 16'sd3;
    req_len[2*LW +: LW] = 8'd2;
    req_valid = 4'b0100;
    wait_grant(g0 + 1);
    req_valid = '0;
    wait_done(d0);
    chk("mr_res", d_res[d0], 36);
    chk("mr_id", d_id[d0], 2);
    chk("mr_count", d_n - d0, 1);
    chk("no_foreign_ready", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
